// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave frame engine.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_ADDR_W = 7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with registered edge strobes and START/STOP detection.
// sda is aligned with the strobes so a strobe and its sampled SDA level belong together.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];
  assign sda     = sda_hist;

  // Bus idles high, so the chain resets to 1 to avoid a false event after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_hist  <= 1'b1;
      sda_hist  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
      scl_hist  <= scl_now;
      sda_hist  <= sda_now;
      scl_rise  <= scl_now & ~scl_hist;
      scl_fall  <= ~scl_now & scl_hist;
      start_det <= scl_now & scl_hist & sda_hist & ~sda_now;
      stop_det  <= scl_now & scl_hist & ~sda_hist & sda_now;
    end
  end

endmodule

// File: rtl/i2c_slave_frame.sv
// Slave-side I2C frame engine: address match, write-byte sink, read-byte source.
// state        | meaning
// ST_IDLE      | bus ignored until START
// ST_ADDR      | shifting address + R/W
// ST_ADDR_ACK  | driving address ACK
// ST_RX_BYTE   | shifting a write byte
// ST_RX_ACK    | driving data ACK
// ST_TX_BYTE   | driving a read byte, MSB first
// ST_TX_ACK    | SDA released, sampling master ACK/NACK
// ST_WAIT_STOP | released, waiting for STOP or START
module i2c_slave_frame
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  slave_clk,
  input  logic                  slave_rst_n,
  input  logic                  slave_scl_in,
  input  logic                  slave_sda_in,
  output logic                  slave_sda_oe,
  output logic [I2C_BYTE_W-1:0] slave_rx_data,
  output logic                  slave_rx_valid,
  input  logic                  slave_rx_ready,
  input  logic [I2C_BYTE_W-1:0] slave_tx_data,
  output logic                  slave_tx_req,
  output logic                  slave_rw,
  output logic                  slave_busy
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (slave_clk),
    .rst_n     (slave_rst_n),
    .scl_raw   (slave_scl_in),
    .sda_raw   (slave_sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e            state, state_n;
  logic [2:0]            bit_cnt, cnt_n;
  logic [I2C_BYTE_W-1:0] shift, shift_n;
  logic                  byte_full, full_n;
  logic                  sda_oe, oe_n;
  logic [I2C_BYTE_W-1:0] rx_data, rx_data_n;
  logic                  rx_valid, rx_valid_n;
  logic                  tx_req, tx_req_n;
  logic                  rw, rw_n;
  logic                  busy, busy_n;
  logic                  take_bit;

  // byte_full marks that all 8 bits are in, since the 3-bit counter has wrapped to 0.
  assign take_bit = scl_rise & ~byte_full;

  always_ff @(posedge slave_clk or negedge slave_rst_n) begin
    if (!slave_rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shift     <= '0;
      byte_full <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      shift     <= shift_n;
      byte_full <= full_n;
      sda_oe    <= oe_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      tx_req    <= tx_req_n;
      rw        <= rw_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = bit_cnt;
    shift_n    = shift;
    full_n     = byte_full;
    oe_n       = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    rw_n       = rw;
    busy_n     = busy;

    if (stop_det) begin
      state_n = ST_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = 3'd0;
      full_n  = 1'b0;
    end else if (start_det) begin
      state_n = ST_ADDR;
      oe_n    = 1'b0;
      cnt_n   = 3'd0;
      full_n  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
        end
        ST_ADDR: begin
          if (take_bit) begin
            shift_n = {shift[I2C_BYTE_W-2:0], sda};
            cnt_n   = bit_cnt + 3'd1;
            full_n  = (bit_cnt == 3'd7);
          end else if (scl_fall && byte_full) begin
            full_n = 1'b0;
            if (shift[I2C_BYTE_W-1:1] == SLAVE_ADDR) begin
              oe_n    = 1'b1;
              rw_n    = shift[0];
              busy_n  = 1'b1;
              state_n = ST_ADDR_ACK;
            end else begin
              oe_n    = 1'b0;
              busy_n  = 1'b0;
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = 3'd0;
            if (rw) begin
              shift_n  = slave_tx_data;
              tx_req_n = 1'b1;
              oe_n     = ~slave_tx_data[I2C_BYTE_W-1];
              state_n  = ST_TX_BYTE;
            end else begin
              oe_n    = 1'b0;
              state_n = ST_RX_BYTE;
            end
          end
        end
        ST_RX_BYTE: begin
          if (take_bit) begin
            shift_n = {shift[I2C_BYTE_W-2:0], sda};
            cnt_n   = bit_cnt + 3'd1;
            full_n  = (bit_cnt == 3'd7);
          end else if (scl_fall && byte_full) begin
            full_n = 1'b0;
            if (slave_rx_ready) begin
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
              oe_n       = 1'b1;
              state_n    = ST_RX_ACK;
            end else begin
              oe_n    = 1'b0;
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            oe_n    = 1'b0;
            state_n = ST_RX_BYTE;
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              cnt_n   = 3'd0;
              oe_n    = 1'b0;
              state_n = ST_TX_ACK;
            end else begin
              cnt_n   = bit_cnt + 3'd1;
              shift_n = {shift[I2C_BYTE_W-2:0], 1'b0};
              oe_n    = ~shift[I2C_BYTE_W-2];
            end
          end
        end
        ST_TX_ACK: begin
          // Still here at the fall means the preceding rise sampled ACK.
          if (scl_rise && sda == NACK) begin
            state_n = ST_WAIT_STOP;
          end else if (scl_fall) begin
            cnt_n    = 3'd0;
            shift_n  = slave_tx_data;
            tx_req_n = 1'b1;
            oe_n     = ~slave_tx_data[I2C_BYTE_W-1];
            state_n  = ST_TX_BYTE;
          end
        end
        ST_WAIT_STOP: begin
          oe_n = 1'b0;
        end
        default: begin
          state_n = ST_IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  assign slave_sda_oe   = sda_oe;
  assign slave_rx_data  = rx_data;
  assign slave_rx_valid = rx_valid;
  assign slave_tx_req   = tx_req;
  assign slave_rw       = rw;
  assign slave_busy     = busy;

endmodule

// File: tb/tb_i2c_slave_frame.sv
// Bit-banged I2C master against the slave frame engine, with a transaction-level model.
module tb_i2c_slave_frame;
  import i2c_pkg::*;

  localparam logic [6:0] SADDR = 7'h50;
  localparam int         Q     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ready = 1'b1;
  logic       sda_bus;
  logic       sda_oe, rx_valid, tx_req, rw, busy;
  logic [7:0] rx_data, tx_data;

  logic [7:0] tx_buf [8];
  int         tx_base = 0;
  int         tx_req_cnt = 0;
  int         exp_txreq = 0;
  logic [2:0] tx_idx;
  logic [7:0] exp_q [$];
  logic [7:0] exp_byte;
  int         oe_cycles = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic [7:0] td [4];
  logic       trdy [4];

  assign sda_bus = m_sda & ~sda_oe;
  assign tx_idx  = 3'(tx_req_cnt - tx_base);
  assign tx_data = tx_buf[tx_idx];

  always #5 clk = ~clk;

  i2c_slave_frame #(.SLAVE_ADDR(SADDR), .SYNC_STAGES(2)) dut (
    .slave_clk      (clk),
    .slave_rst_n    (rst_n),
    .slave_scl_in   (m_scl),
    .slave_sda_in   (sda_bus),
    .slave_sda_oe   (sda_oe),
    .slave_rx_data  (rx_data),
    .slave_rx_valid (rx_valid),
    .slave_rx_ready (rx_ready),
    .slave_tx_data  (tx_data),
    .slave_tx_req   (tx_req),
    .slave_rw       (rw),
    .slave_busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every received byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (sda_oe) oe_cycles = oe_cycles + 1;
    if (rx_valid && tx_req) check("rx_tx_overlap", 32'(1), 32'(0));
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_valid with %0h, expected no byte", rx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(exp_byte));
      end
    end
    if (tx_req) tx_req_cnt = tx_req_cnt + 1;
  end

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (m_scl) begin
      m_sda = 1'b1; wait_q(Q);
      m_sda = 1'b0; wait_q(2*Q);
      m_scl = 1'b0; wait_q(Q);
    end else begin
      m_sda = 1'b1; wait_q(Q);
      m_scl = 1'b1; wait_q(2*Q);
      m_sda = 1'b0; wait_q(2*Q);
      m_scl = 1'b0; wait_q(Q);
    end
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q(Q);
    m_scl = 1'b1; wait_q(2*Q);
    m_sda = 1'b1; wait_q(2*Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b;    wait_q(Q);
    m_scl = 1'b1; wait_q(2*Q);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    b = sda_bus;  wait_q(Q);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(mack);
  endtask

  // One transaction; model: ACK only on address match, write ACK follows rx_ready
  // until the first NACK, a read returns the source bytes (all ones on mismatch).
  task automatic xfer(input logic [6:0] a, input logic r, input int n, input logic stop);
    logic       ack, match, alive;
    logic [7:0] got;
    match = (a == SADDR);
    if (r && match) begin
      tx_base = tx_req_cnt;
      for (int i = 0; i < 4; i++) tx_buf[i] = td[i];
      exp_txreq += n;
    end
    bus_start();
    rx_ready = 1'b1;
    put_byte({a, r}, ack);
    check("addr_ack", 32'(ack), 32'(match ? ACK : NACK));
    if (match) begin
      check("busy_after_match", 32'(busy), 32'(1));
      check("rw_latched", 32'(rw), 32'(r));
    end else begin
      check("busy_mismatch", 32'(busy), 32'(0));
    end
    alive = match;
    for (int i = 0; i < n; i++) begin
      if (!r) begin
        rx_ready = trdy[i];
        if (alive && trdy[i]) exp_q.push_back(td[i]);
        put_byte(td[i], ack);
        check("data_ack", 32'(ack), 32'((alive && trdy[i]) ? ACK : NACK));
        alive = alive && trdy[i];
      end else begin
        get_byte(got, (i == n-1) ? NACK : ACK);
        check("read_byte", 32'(got), 32'(match ? td[i] : 8'hFF));
      end
    end
    if (r && match) check("released_after_nack", 32'(sda_oe), 32'(0));
    if (stop) begin
      bus_stop();
      check("busy_after_stop", 32'(busy), 32'(0));
    end
  endtask

  task automatic set_d(input logic [7:0] d0, input logic [7:0] d1, input logic r0, input logic r1);
    td[0] = d0; td[1] = d1; td[2] = 8'h00; td[3] = 8'h00;
    trdy[0] = r0; trdy[1] = r1; trdy[2] = 1'b1; trdy[3] = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

  initial begin
    logic       b, ack, r, stp;
    logic [6:0] a;
    int         n, oe_snap;
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
    set_d(8'h00, 8'h00, 1'b1, 1'b1);

    wait_q(4);
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_rx_data", 32'(rx_data), 32'(0));
    check("rst_rx_valid", 32'(rx_valid), 32'(0));
    check("rst_tx_req", 32'(tx_req), 32'(0));
    check("rst_rw", 32'(rw), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst_n = 1'b1;
    wait_q(8);

    set_d(8'hA5, 8'h00, 1'b1, 1'b1);
    xfer(SADDR, 1'b0, 1, 1'b1);
    check("rx_data_hold", 32'(rx_data), 32'(8'hA5));

    oe_snap = oe_cycles;
    set_d(8'h11, 8'h00, 1'b1, 1'b1);
    xfer(7'h21, 1'b0, 1, 1'b1);
    check("mismatch_oe_cycles", 32'(oe_cycles - oe_snap), 32'(0));

    set_d(8'h3C, 8'hC3, 1'b1, 1'b1);
    xfer(SADDR, 1'b1, 2, 1'b1);

    set_d(8'h77, 8'h12, 1'b0, 1'b1);
    xfer(SADDR, 1'b0, 2, 1'b1);

    set_d(8'h01, 8'h00, 1'b1, 1'b1);
    xfer(SADDR, 1'b0, 1, 1'b0);
    set_d(8'h96, 8'h00, 1'b1, 1'b1);
    xfer(SADDR, 1'b1, 1, 1'b1);

    // Reset while the slave is pulling SDA low for a 0 bit of a read byte.
    tx_base = tx_req_cnt;
    for (int i = 0; i < 8; i++) tx_buf[i] = 8'h00;
    exp_txreq += 1;
    bus_start();
    put_byte({SADDR, 1'b1}, ack);
    check("rst_test_addr_ack", 32'(ack), 32'(ACK));
    for (int i = 0; i < 3; i++) get_bit(b);
    check("oe_before_reset", 32'(sda_oe), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_sda_oe", 32'(sda_oe), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_rw", 32'(rw), 32'(0));
    check("async_rst_rx_data", 32'(rx_data), 32'(0));
    check("async_rst_rx_valid", 32'(rx_valid), 32'(0));
    check("async_rst_tx_req", 32'(tx_req), 32'(0));
    wait_q(4);
    rst_n = 1'b1;
    wait_q(4);
    bus_stop();
    set_d(8'h5A, 8'h00, 1'b1, 1'b1);
    xfer(SADDR, 1'b0, 1, 1'b1);

    for (int t = 0; t < 12; t++) begin
      a   = ($urandom_range(0, 1) == 1) ? SADDR : 7'($urandom_range(0, 127));
      r   = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) begin
        td[i]   = 8'($urandom);
        trdy[i] = ($urandom_range(0, 4) != 0);
      end
      stp = (t == 11) || ($urandom_range(0, 3) != 0);
      xfer(a, r, n, stp);
    end

    wait_q(8);
    check("rx_queue_drained", 32'(exp_q.size()), 32'(0));
    check("tx_req_count", 32'(tx_req_cnt), 32'(exp_txreq));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_frame.md
Name: i2c_slave_frame

Overview:
- Slave-side I2C frame engine; the counterpart of the master frame mux/demux and ACK path.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Shifts in the 7-bit address and R/W bit, compares the address, and ACKs on a match.
- Then receives write bytes to a local sink, or transmits read bytes from a local source with master ACK/NACK handling. SDA is driven open-drain through an output-enable.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this slave responds to.
- SYNC_STAGES, 2, synchronizer depth on SCL/SDA inputs (legal value ≥2).

Ports:
- slave_clk  in  1  system clock; must be ≥8× the SCL frequency.
- slave_rst_n  in  1  reset, asynchronous, active-low.
- slave_scl_in  in  1  raw SCL from the bus.
- slave_sda_in  in  1  raw SDA from the bus.
- slave_sda_oe  out  1  1 = pull SDA low; 0 = release.
- slave_rx_data  out  8  last received write byte.
- slave_rx_valid  out  1  one-cycle pulse; rx_data is valid.
- slave_rx_ready  in  1  sink can accept a byte; sampled at bit 8.
- slave_tx_data  in  8  byte to transmit on a read.
- slave_tx_req  out  1  one-cycle pulse; tx_data was loaded, present the next byte.
- slave_rw  out  1  R/W bit of the current transfer (1 = read).
- slave_busy  out  1  high from address match until STOP or mismatch.

Behaviour:
- Clock and reset:
  - One clock: slave_clk. Reset: slave_rst_n, asynchronous assert, active-low.
  - Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, rw=0, busy=0, FSM=IDLE, bit counter=0.
- Input conditioning and events:
  - SCL and SDA each pass through SYNC_STAGES flops plus one history flop.
  - scl_rise and scl_fall are single-cycle strobes.
  - START = SDA 1→0 while SCL high. STOP = SDA 0→1 while SCL high.
  - Events appear SYNC_STAGES+1 cycles after the bus edge.
- Bit timing:
  - Data is sampled on scl_rise, MSB first.
  - sda_oe changes only on scl_fall (or on STOP/START/reset).
- FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- IDLE: on START → ADDR, bit counter=0.
- ADDR: shift 8 bits (addr[6:0], rw).
  - On the scl_fall after bit 8: if addr==SLAVE_ADDR, set sda_oe=1, latch rw, busy=1, → ADDR_ACK.
  - Otherwise → WAIT_STOP with sda_oe=0.
- ADDR_ACK: on the next scl_fall:
  - rw=0 → release SDA, → RX_BYTE.
  - rw=1 → load tx_data into the shift register, pulse tx_req, drive bit 7 (sda_oe=~bit), → TX_BYTE.
- RX_BYTE: shift 8 bits. On the scl_fall after bit 8:
  - rx_ready=1 → rx_data=shift, pulse rx_valid, sda_oe=1 (ACK), → RX_ACK.
  - rx_ready=0 → no rx_valid, sda_oe=0 (NACK), → WAIT_STOP.
- RX_ACK: on scl_fall → release SDA, → RX_BYTE.
- TX_BYTE:
  - On each scl_fall, drive the next bit: sda_oe = ~bit.
  - After the 8th bit's scl_fall, release SDA → TX_ACK.
- TX_ACK: sample SDA on scl_rise.
  - 0 (ACK): on scl_fall, load tx_data, pulse tx_req, drive bit 7, → TX_BYTE.
  - 1 (NACK): keep SDA released, → WAIT_STOP.
- WAIT_STOP: SDA released; ignore bits; STOP → IDLE; START → ADDR.
- Global overrides:
  - STOP in any state → IDLE, sda_oe=0, busy=0.
  - Repeated START in any state → ADDR, sda_oe=0, bit counter=0, busy held until the next address decision.
  - If START/STOP and scl_fall coincide, START/STOP wins.
- Bit counter: 3-bit, wraps 7→0 at the end of each byte. The 9th (ACK) clock is handled by the *_ACK states, not the counter.
- Reset mid-transfer: SDA is released immediately (asynchronous). The engine ignores the bus until the next START.
- rx_valid and tx_req never assert in the same cycle, and never while in IDLE or WAIT_STOP.

Decomposition:
- Shared package i2c_pkg: FSM state enum, ACK=1'b0 and NACK=1'b1 constants, I2C_BYTE_W=8, I2C_ADDR_W=7.
- One sub-module i2c_bus_sync: synchronizers, edge strobes, START/STOP detection.
- FSM and shift register stay in i2c_slave_frame.

Test Plan:
- Write match: START, 0xA0 (0x50, W), 0xA5, STOP, rx_ready=1:
  - slave ACKs the address and the data byte.
  - rx_valid pulses once with rx_data=0xA5.
  - busy returns to 0 after STOP.
- Address mismatch: START, 0x42, 0x11, STOP:
  - sda_oe stays 0 throughout.
  - No rx_valid; busy stays 0.
- Read: START, 0xA1, tx_data=0x3C then 0xC3; master ACKs byte 1, NACKs byte 2:
  - Bus shows 0x3C then 0xC3.
  - tx_req pulses twice.
  - SDA released after the NACK; FSM in WAIT_STOP until STOP.
- Sink back-pressure: write 0xA0, 0x77 with rx_ready=0:
  - 9th clock sees SDA released (NACK).
  - No rx_valid; FSM in WAIT_STOP.
- Repeated START: write 0xA0, 0x01, then Sr, 0xA1:
  - rx_valid for 0x01.
  - rw becomes 1; tx_req pulses; a read proceeds.
- Reset mid-read: assert rst_n low while driving bit 3 of a TX byte:
  - sda_oe=0 within the same cycle (asynchronous).
  - All outputs at reset values.
  - Next START + 0xA0 is ACKed normally.
